// File: rtl/temp_sample_scheduler_pkg.sv
// Shared types and constants for the temperature sample scheduler.
// Register map, CTRL bit positions, FSM state type and the tick divider helper.
package temp_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_REQ, S_WAIT} sched_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_THRESH = 2'd2;

    localparam int unsigned CTRL_PERIODIC_EN = 0;
    localparam int unsigned CTRL_ONESHOT     = 1;
    localparam int unsigned CTRL_CLR_ERR     = 2;

    // Never returns 0 so the prescaler always has a legal divide ratio.
    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
        if (tick_hz == 0 || clk_hz < tick_hz) return 1;
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/temp_sample_scheduler_if.sv
// CPU register bus and sensor control bus of the temperature sample scheduler.
// The scheduler uses the master modport; the CPU/sensor side uses the slave modport.
interface temp_sample_scheduler_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        sens_we;
    logic [31:0] sens_wdata;
    logic [31:0] sens_rdata;
    logic        sens_done;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, sens_rdata, sens_done,
        output sens_we, sens_wdata
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, sens_rdata, sens_done,
        input  sens_we, sens_wdata
    );
endinterface

// File: rtl/temp_sample_scheduler_tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every DIV clock cycles.
module tick_prescaler #(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                    cnt_q <= cnt_q + W'(1);
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/temp_sample_scheduler.sv
// Periodic / one-shot temperature sensor sequencer with timeout, sample latch and hysteresis alarm.
// Define TEMP_SCHED_AVG_EN to report a 4-sample moving average instead of the raw sample.
module temp_sample_scheduler
    import temp_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter logic [15:0] PERIOD_RST  = 16'd1000
) (
    input  logic                            clk,
    input  logic                            reset,
    temp_sample_scheduler_if.master         bus,
    output logic [15:0]                     temp_out,
    output logic                            temp_valid,
    output logic [15:0]                     sample_cnt,
    output logic                            alarm,
    output logic                            timeout_err,
    output logic                            busy
);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    sched_state_t state_q, state_d;
    logic         tick;
    logic         periodic_en_q;
    logic [15:0]  period_q, period_act_q, period_act_d, period_last;
    logic [15:0]  thr_hi_q, thr_lo_q;
    logic [15:0]  tick_cnt_q, tick_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]  temp_q, sample_cnt_q, report;
    logic         temp_valid_q, alarm_q, timeout_err_q;
    logic         ctrl_wr, oneshot, sample_take, tmo_hit;
    logic         unused_rdata;

    tick_prescaler #(
        .DIV (tick_div(CLK_HZ, TICK_HZ))
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign ctrl_wr      = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
    assign oneshot      = ctrl_wr && bus.cfg_wdata[CTRL_ONESHOT];
    assign unused_rdata = ^bus.sens_rdata[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periodic_en_q <= 1'b0;
            period_q      <= PERIOD_RST;
            thr_hi_q      <= 16'hFFFF;
            thr_lo_q      <= 16'h0000;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_CTRL:   periodic_en_q <= bus.cfg_wdata[CTRL_PERIODIC_EN];
                ADDR_PERIOD: period_q      <= bus.cfg_wdata[15:0];
                ADDR_THRESH: begin
                    thr_hi_q <= bus.cfg_wdata[15:0];
                    thr_lo_q <= bus.cfg_wdata[31:16];
                end
                default: ;
            endcase
        end
    end

    // A period of 0 counts as 1 tick.
    assign period_last = (period_act_q == 16'd0) ? 16'd0 : period_act_q - 16'd1;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        period_act_d = period_act_q;
        tmo_cnt_d    = tmo_cnt_q;
        sample_take  = 1'b0;
        tmo_hit      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (oneshot)            state_d = S_REQ;
                else if (periodic_en_q) state_d = S_ARM;
            end
            S_ARM: begin
                if (oneshot)             state_d = S_REQ;
                else if (!periodic_en_q) state_d = S_IDLE;
                else if (tick) begin
                    if (tick_cnt_q == period_last) state_d = S_REQ;
                    else                           tick_cnt_d = tick_cnt_q + 16'd1;
                end
            end
            S_REQ: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a timeout in the same cycle
                if (bus.sens_done) begin
                    sample_take = 1'b1;
                    state_d     = periodic_en_q ? S_ARM : S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = periodic_en_q ? S_ARM : S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ARM && state_q != S_ARM) begin
            tick_cnt_d   = 16'd0;
            period_act_d = period_q;
        end
    end

`ifdef TEMP_SCHED_AVG_EN
    logic [15:0] avg_q [4];
    logic [15:0] avg_d [4];
    logic [17:0] avg_sum;
    logic        fresh_q;

    // First sample after idling fills every slot so the average starts at that sample.
    always_comb begin
        avg_d[0] = bus.sens_rdata[15:0];
        for (int i = 1; i < 4; i++) avg_d[i] = fresh_q ? bus.sens_rdata[15:0] : avg_q[i-1];
        avg_sum = {2'b00, avg_d[0]} + {2'b00, avg_d[1]} + {2'b00, avg_d[2]} + {2'b00, avg_d[3]};
        report  = avg_sum[17:2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) avg_q[i] <= 16'h0000;
            fresh_q <= 1'b1;
        end else if (sample_take) begin
            for (int i = 0; i < 4; i++) avg_q[i] <= avg_d[i];
            fresh_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            fresh_q <= 1'b1;
        end
    end
`else
    assign report = bus.sens_rdata[15:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= 16'd0;
            period_act_q  <= 16'd0;
            tmo_cnt_q     <= '0;
            temp_q        <= 16'h0000;
            temp_valid_q  <= 1'b0;
            sample_cnt_q  <= 16'd0;
            alarm_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            period_act_q <= period_act_d;
            tmo_cnt_q    <= tmo_cnt_d;
            temp_valid_q <= sample_take;
            if (sample_take) begin
                temp_q       <= report;
                sample_cnt_q <= sample_cnt_q + 16'd1;
                if ($signed(report) >= $signed(thr_hi_q))     alarm_q <= 1'b1;
                else if ($signed(report) < $signed(thr_lo_q)) alarm_q <= 1'b0;
            end
            if (tmo_hit)                                          timeout_err_q <= 1'b1;
            else if (ctrl_wr && bus.cfg_wdata[CTRL_CLR_ERR])      timeout_err_q <= 1'b0;
        end
    end

    assign bus.sens_we    = (state_q == S_REQ);
    assign bus.sens_wdata = 32'h0000_0001;
    assign busy           = (state_q == S_REQ) || (state_q == S_WAIT);
    assign temp_out       = temp_q;
    assign temp_valid     = temp_valid_q;
    assign sample_cnt     = sample_cnt_q;
    assign alarm          = alarm_q;
    assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Self-checking bench for temp_sample_scheduler: randomized sensor timing/data against a
// behavioural model of reported value, sample count, alarm hysteresis and request timing.
module tb_temp_sample_scheduler;
    import temp_sched_pkg::*;

    localparam int unsigned CLK_HZ     = 10;
    localparam int unsigned TICK_HZ    = 1;
    localparam int          DIV        = 10;
    localparam int          T          = 1000;
    localparam logic [15:0] PERIOD_RST = 16'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] temp_out, sample_cnt;
    logic        temp_valid, alarm, timeout_err, busy;

    always #5 clk = ~clk;

    temp_sample_scheduler_if sif ();

    temp_sample_scheduler #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .TIMEOUT_CYC (T),
        .PERIOD_RST  (PERIOD_RST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (sif),
        .temp_out    (temp_out),
        .temp_valid  (temp_valid),
        .sample_cnt  (sample_cnt),
        .alarm       (alarm),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Sensor model and event log, updated 1 time unit after every rising edge.
    int          cyc = 0;
    int          n_req = 0;
    int          n_valid = 0;
    int          valid_cyc = 0;
    int          req_q[$];
    int          dly_q[$];
    logic [15:0] dat_q[$];
    bit          mute = 1'b0;
    int          conv_delay = 10;
    logic [15:0] next_data = 16'h0;
    bit          pending = 1'b0;
    int          due = 0;
    logic [15:0] pdata = 16'h0;

    // Behavioural reference state
    logic [15:0] m_hi = 16'hFFFF;
    logic [15:0] m_lo = 16'h0000;
    bit          m_alarm = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_periodic = 1'b0;
    bit          m_fresh = 1'b1;
    logic [15:0] m_hist[4];

    initial begin
        sif.sens_done  = 1'b0;
        sif.sens_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                pending       = 1'b0;
                sif.sens_done = 1'b0;
            end else begin
                if (sif.sens_we) begin
                    n_req++;
                    req_q.push_back(cyc);
                    dly_q.push_back(conv_delay);
                    dat_q.push_back(next_data);
                    if (!mute) begin
                        pending = 1'b1;
                        due     = cyc + conv_delay;
                        pdata   = next_data;
                    end
                end
                if (temp_valid) begin
                    n_valid++;
                    valid_cyc = cyc;
                end
                if (pending && cyc == due) begin
                    sif.sens_done  = 1'b1;
                    sif.sens_rdata = {16'($urandom), pdata};
                    pending        = 1'b0;
                end else begin
                    sif.sens_done = 1'b0;
                end
            end
        end
    end

    task automatic model_sample(input logic [15:0] raw, output logic [15:0] rep);
`ifdef TEMP_SCHED_AVG_EN
        int s;
        if (m_fresh) begin
            for (int i = 0; i < 4; i++) m_hist[i] = raw;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = raw;
        end
        s   = int'(m_hist[0]) + int'(m_hist[1]) + int'(m_hist[2]) + int'(m_hist[3]);
        rep = 16'(s / 4);
`else
        rep = raw;
`endif
        m_fresh = !m_periodic;
        m_cnt   = m_cnt + 16'd1;
        if ($signed(rep) >= $signed(m_hi))     m_alarm = 1'b1;
        else if ($signed(rep) < $signed(m_lo)) m_alarm = 1'b0;
    endtask

    task automatic model_reset();
        m_hi = 16'hFFFF; m_lo = 16'h0000; m_alarm = 1'b0; m_cnt = 16'd0;
        m_periodic = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sif.cfg_we = 1'b1; sif.cfg_addr = a; sif.cfg_wdata = d;
        @(negedge clk);
        sif.cfg_we = 1'b0;
    endtask

    task automatic ctrl_write(input bit pen, input bit one, input bit clr);
        cfg_write(ADDR_CTRL, {29'd0, clr, one, pen});
    endtask

    task automatic wait_req(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (n_req >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (n_valid >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.cfg_we = 1'b0; sif.cfg_addr = 2'd0; sif.cfg_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({temp_out, sample_cnt, temp_valid, alarm, timeout_err, busy, sif.sens_we} !== 37'd0) begin
            errors++;
            $display("FAIL reset outputs: got temp=%h cnt=%h v=%b a=%b e=%b b=%b we=%b, want all 0",
                     temp_out, sample_cnt, temp_valid, alarm, timeout_err, busy, sif.sens_we);
        end
        checks++;
        if (sif.sens_wdata !== 32'h1) begin
            errors++; $display("FAIL sens_wdata: got %h want 00000001", sif.sens_wdata);
        end
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (n_req != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle after reset: got req=%0d busy=%b want 0 0", n_req, busy);
        end
    endtask

    task automatic test_oneshot();
        bit ok; logic [15:0] exp; int r0 = n_req;
        conv_delay = 600; next_data = 16'h00FA;
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_valid(n_valid + 1, 2000, ok);
        model_sample(16'h00FA, exp);
        checks++;
        if (!ok) begin errors++; $display("FAIL oneshot valid: got none want pulse"); end
        checks++;
        if (temp_out !== exp) begin
            errors++; $display("FAIL oneshot temp_out: got %h want %h", temp_out, exp);
        end
        checks++;
        if (sample_cnt !== m_cnt || alarm !== m_alarm) begin
            errors++; $display("FAIL oneshot cnt/alarm: got %0d/%b want %0d/%b",
                               sample_cnt, alarm, m_cnt, m_alarm);
        end
        checks++;
        if (n_req - r0 != 1 || valid_cyc - req_q[req_q.size()-1] != 601) begin
            errors++; $display("FAIL oneshot req/latency: got %0d/%0d want 1/601",
                               n_req - r0, valid_cyc - req_q[req_q.size()-1]);
        end
        @(negedge clk);
        checks++;
        if (temp_valid !== 1'b0) begin
            errors++; $display("FAIL oneshot valid width: got %b want 0 on 2nd cycle", temp_valid);
        end
    endtask

    task automatic test_periodic(input int per, input int nsamp, input bit seq);
        bit ok; logic [15:0] exp; int pe, lo, iv;
        pe = (per == 0) ? 1 : per;
        conv_delay = $urandom_range(4, 40);
        next_data  = seq ? 16'd100 : 16'($urandom);
        cfg_write(ADDR_PERIOD, 32'(per));
        ctrl_write(1'b1, 1'b0, 1'b0);
        m_periodic = 1'b1;
        for (int k = 0; k < nsamp; k++) begin
            wait_req(n_req + 1, DIV * (pe + 1) + 100, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL periodic req %0d: got none want request", k); end
            if (k == nsamp - 1) begin
                ctrl_write(1'b0, 1'b0, 1'b0);
                m_periodic = 1'b0;
            end
            wait_valid(n_valid + 1, 100, ok);
            model_sample(dat_q[dat_q.size()-1], exp);
            checks++;
            if (!ok || temp_out !== exp || sample_cnt !== m_cnt || alarm !== m_alarm) begin
                errors++;
                $display("FAIL periodic sample %0d: got ok=%b t=%h c=%0d a=%b want t=%h c=%0d a=%b",
                         k, ok, temp_out, sample_cnt, alarm, exp, m_cnt, m_alarm);
            end
            checks++;
            if (valid_cyc - req_q[req_q.size()-1] != dly_q[dly_q.size()-1] + 1) begin
                errors++; $display("FAIL periodic latency %0d: got %0d want %0d", k,
                                   valid_cyc - req_q[req_q.size()-1], dly_q[dly_q.size()-1] + 1);
            end
            if (k > 0) begin
                iv = req_q[req_q.size()-1] - req_q[req_q.size()-2];
                lo = dly_q[dly_q.size()-2] + 2 + DIV * (pe - 1);
                checks++;
                if (iv < lo || iv > lo + DIV - 1) begin
                    errors++; $display("FAIL periodic interval %0d: got %0d want %0d..%0d",
                                       k, iv, lo, lo + DIV - 1);
                end
            end
            conv_delay = $urandom_range(4, 40);
            next_data  = seq ? 16'(100 * (k + 2)) : 16'($urandom);
        end
        begin
            int r0 = n_req;
            repeat (DIV * (pe + 2) + 50) @(negedge clk);
            checks++;
            if (n_req != r0 || busy !== 1'b0) begin
                errors++; $display("FAIL periodic stop: got req+%0d busy=%b want 0 0", n_req - r0, busy);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; int n0, t, c0, v0;
        mute = 1'b1; c0 = n_req; v0 = n_valid;
        cfg_write(ADDR_PERIOD, 32'd1);
        ctrl_write(1'b1, 1'b0, 1'b0);
        m_periodic = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            wait_req(c0 + rep + 1, (rep == 0) ? 100 : DIV + 5, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL timeout req %0d: got none want request", rep); end
            n0 = req_q[req_q.size()-1];
            if (rep == 1) begin
                cfg_write(ADDR_PERIOD, 32'd50);
                while (cyc < n0 + T) @(negedge clk);
                sif.cfg_we = 1'b1; sif.cfg_addr = ADDR_CTRL; sif.cfg_wdata = 32'h5;
                @(negedge clk);
                sif.cfg_we = 1'b0;
            end
            t = 0;
            while (timeout_err !== 1'b1 && t < T + 20) begin @(negedge clk); t++; end
            checks++;
            if (timeout_err !== 1'b1 || cyc - n0 != T + 1) begin
                errors++; $display("FAIL timeout %0d: got err=%b after %0d want 1 after %0d",
                                   rep, timeout_err, cyc - n0, T + 1);
            end
            checks++;
            if (sample_cnt !== m_cnt || n_valid != v0 || busy !== 1'b0) begin
                errors++; $display("FAIL timeout %0d side effects: got cnt=%0d v=%0d busy=%b want %0d %0d 0",
                                   rep, sample_cnt, n_valid - v0, busy, m_cnt, 0);
            end
            ctrl_write(rep == 0, 1'b0, 1'b1);
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++; $display("FAIL clr_err %0d: got %b want 0", rep, timeout_err);
            end
        end
        m_periodic = 1'b0; m_fresh = 1'b1;
        begin
            int r0 = n_req;
            repeat (60) @(negedge clk);
            checks++;
            if (n_req != r0) begin
                errors++; $display("FAIL timeout stop: got %0d extra requests want 0", n_req - r0);
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_collide();
        bit ok; logic [15:0] exp; int r0 = n_req; int v0;
        conv_delay = T; next_data = 16'($urandom);
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_req(r0 + 1, 20, ok);
        repeat (10) @(negedge clk);
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_valid(n_valid + 1, T + 50, ok);
        model_sample(next_data, exp);
        checks++;
        if (!ok || temp_out !== exp || sample_cnt !== m_cnt) begin
            errors++; $display("FAIL collide data: got ok=%b t=%h c=%0d want t=%h c=%0d",
                               ok, temp_out, sample_cnt, exp, m_cnt);
        end
        checks++;
        if (timeout_err !== 1'b0 || n_req - r0 != 1) begin
            errors++; $display("FAIL collide err/req: got err=%b req=%0d want 0 1",
                               timeout_err, n_req - r0);
        end
        r0 = n_req; v0 = n_valid;
        conv_delay = T + 1;
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_req(r0 + 1, 20, ok);
        for (int t = 0; t < T + 20 && timeout_err !== 1'b1; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || n_valid != v0 || sample_cnt !== m_cnt) begin
            errors++; $display("FAIL late done: got err=%b v=%0d c=%0d want 1 0 %0d",
                               timeout_err, n_valid - v0, sample_cnt, m_cnt);
        end
        ctrl_write(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_alarm();
        bit ok; logic [15:0] exp;
        logic [15:0] vals[12];
        vals[0] = 16'd100; vals[1] = 16'd290; vals[2] = 16'd300; vals[3] = 16'd290;
        vals[4] = 16'd279; vals[5] = 16'h8000; vals[6] = 16'd300; vals[7] = 16'hFFF0;
        for (int i = 8; i < 12; i++) vals[i] = 16'($urandom_range(260, 320));
        cfg_write(ADDR_THRESH, {16'd280, 16'd300});
        m_hi = 16'd300; m_lo = 16'd280;
        for (int i = 0; i < 12; i++) begin
            conv_delay = $urandom_range(2, 20); next_data = vals[i];
            ctrl_write(1'b0, 1'b1, 1'b0);
            wait_valid(n_valid + 1, 60, ok);
            model_sample(vals[i], exp);
            checks++;
            if (!ok || temp_out !== exp || alarm !== m_alarm) begin
                errors++; $display("FAIL alarm %0d: got ok=%b t=%h a=%b want t=%h a=%b",
                                   i, ok, temp_out, alarm, exp, m_alarm);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [15:0] exp; int r0 = n_req; int v0;
        conv_delay = 500; next_data = 16'h1234;
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_req(r0 + 1, 20, ok);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({temp_out, sample_cnt, temp_valid, alarm, timeout_err, busy, sif.sens_we} !== 37'd0) begin
            errors++;
            $display("FAIL reset in wait: got temp=%h cnt=%h v=%b a=%b e=%b b=%b we=%b want all 0",
                     temp_out, sample_cnt, temp_valid, alarm, timeout_err, busy, sif.sens_we);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        r0 = n_req; v0 = n_valid;
        repeat (100) @(negedge clk);
        checks++;
        if (n_req != r0 || n_valid != v0 || busy !== 1'b0) begin
            errors++; $display("FAIL after reset: got req+%0d valid+%0d busy=%b want 0 0 0",
                               n_req - r0, n_valid - v0, busy);
        end
        conv_delay = 5; next_data = 16'($urandom);
        ctrl_write(1'b0, 1'b1, 1'b0);
        wait_valid(v0 + 1, 40, ok);
        model_sample(next_data, exp);
        checks++;
        if (!ok || temp_out !== exp || sample_cnt !== 16'd1 || alarm !== m_alarm) begin
            errors++; $display("FAIL post-reset sample: got ok=%b t=%h c=%0d a=%b want t=%h c=1 a=%b",
                               ok, temp_out, sample_cnt, alarm, exp, m_alarm);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic(3, 5, 1'b1);
        test_periodic(0, 4, 1'b0);
        test_timeout();
        test_collide();
        test_alarm();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
